// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_subtractor_if                                          |
// | Purpose  : Start/busy/done handshake and operand/result bundle for the   |
// |            bit-serial subtractor.                                        |
// | Signals  : start, a, b      - request and operands (controller drives)   |
// |            diff, borrow_out - registered result (subtractor drives)      |
// |            busy, done       - status (subtractor drives)                 |
// | Modports : master - controller side, slave - subtractor side             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             busy;
   logic             done;

   modport master (
      output start, a, b,
      input  diff, borrow_out, busy, done
   );

   modport slave (
      input  start, a, b,
      output diff, borrow_out, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serial_subtractor                                             |
// | Purpose  : Bit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH,   |
// |            one bit per clock, LSB first, borrow carried in a flop.       |
// | Ports    : clk   - rising-edge clock                                     |
// |            rst_n - asynchronous active-low reset                         |
// |            bus   - serial_subtractor_if.slave (start/a/b in,             |
// |                    diff/borrow_out/busy/done out)                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   serial_subtractor_if.slave    bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;

   // Two cascaded half-subtractor cells: (a - b), then (that - borrow_in).
   logic hs1_diff, hs1_borrow;
   logic bit_diff, hs2_borrow, bit_borrow;

   always_comb begin
      hs1_diff   = sa_q[0] ^ sb_q[0];
      hs1_borrow = ~sa_q[0] & sb_q[0];
      bit_diff   = hs1_diff ^ borrow_q;
      hs2_borrow = ~hs1_diff & borrow_q;
      bit_borrow = hs1_borrow | hs2_borrow;
   end

   always_comb begin
      state_d      = state_q;
      sa_d         = sa_q;
      sb_d         = sb_q;
      result_d     = result_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               sa_d     = bus.a;
               sb_d     = bus.b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            result_d = {bit_diff, result_q[WIDTH-1:1]};
            sa_d     = {1'b0, sa_q[WIDTH-1:1]};
            sb_d     = {1'b0, sb_q[WIDTH-1:1]};
            borrow_d = bit_borrow;
            cnt_d    = cnt_q + 1'b1;
            // cnt_q counts bits already processed; the edge that consumes
            // the last bit publishes the full result straight to the outputs.
            if (cnt_q == LAST_BIT) begin
               state_d      = ST_DONE;
               diff_d       = {bit_diff, result_q[WIDTH-1:1]};
               borrow_out_d = bit_borrow;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sa_q         <= '0;
         sb_q         <= '0;
         result_q     <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sa_q         <= sa_d;
         sb_q         <= sb_d;
         result_q     <= result_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_out_q;
   assign bus.busy       = (state_q == ST_SHIFT);
   assign bus.done       = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serial_subtractor                                          |
// | Purpose  : Directed self-checking bench for serial_subtractor, using an  |
// |            8-bit instance and a 4-bit instance for the full sweep.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_serial_subtractor;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   serial_subtractor_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_if #(.WIDTH(4)) bus4 ();

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one operation on the selected instance, starting in IDLE at #1
   // after an edge and returning in IDLE at #1 after an edge.
   task automatic run_op(input bit use4, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] d, output logic bo,
                         output int nbusy, output int ndone,
                         output bit overlap, output bit diff_moved, output bit timeout);
      logic [7:0] d_prev;
      logic       c_busy, c_done;
      logic [7:0] c_diff;
      bit         seen;
      d = '0; bo = 1'b0; nbusy = 0; ndone = 0;
      overlap = 0; diff_moved = 0; timeout = 0; seen = 0;
      if (use4) begin
         bus4.start = 1'b1; bus4.a = av[3:0]; bus4.b = bv[3:0];
         d_prev = {4'h0, bus4.diff};
      end else begin
         bus8.start = 1'b1; bus8.a = av; bus8.b = bv;
         d_prev = bus8.diff;
      end
      @(posedge clk); #1;
      // Operands must be ignored once accepted.
      bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom);
      bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         c_busy = use4 ? bus4.busy : bus8.busy;
         c_done = use4 ? bus4.done : bus8.done;
         c_diff = use4 ? {4'h0, bus4.diff} : bus8.diff;
         if (c_busy && c_done) overlap = 1;
         if (c_busy) begin
            nbusy++;
            if (c_diff !== d_prev) diff_moved = 1;
         end
         if (c_done) begin
            ndone++;
            d    = c_diff;
            bo   = use4 ? bus4.borrow_out : bus8.borrow_out;
            seen = 1;
         end else if (seen) begin
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) timeout = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus8.start = 1'(i % 2); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
         bus4.start = 1'(i % 2); bus4.a = 4'($urandom); bus4.b = 4'($urandom);
         @(posedge clk); #1;
         checks++;
         if (bus8.diff !== 8'h00) begin
            errors++; $display("FAIL reset_diff: got %h expected 00", bus8.diff);
         end
         checks++;
         if (bus8.borrow_out !== 1'b0) begin
            errors++; $display("FAIL reset_borrow: got %b expected 0", bus8.borrow_out);
         end
         checks++;
         if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++; $display("FAIL reset_status: got busy=%b done=%b expected 0/0", bus8.busy, bus8.done);
         end
         checks++;
         if (bus4.diff !== 4'h0 || bus4.busy !== 1'b0 || bus4.done !== 1'b0) begin
            errors++; $display("FAIL reset_w4: got diff=%h busy=%b done=%b expected 0/0/0", bus4.diff, bus4.busy, bus4.done);
         end
      end
      bus8.start = 1'b0; bus4.start = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [7:0] d; logic bo; int nb, nd; bit ov, mv, to;
      run_op(0, 8'd200, 8'd55, d, bo, nb, nd, ov, mv, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: no done pulse within bound"); end
      checks++;
      if (d !== 8'd145) begin errors++; $display("FAIL basic_diff: got %0d expected 145", d); end
      checks++;
      if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b expected 0", bo); end
      checks++;
      if (nb !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", nb); end
      checks++;
      if (nd !== 1) begin errors++; $display("FAIL basic_done_cycles: got %0d expected 1", nd); end
      checks++;
      if (ov) begin errors++; $display("FAIL basic_busy_done_overlap: got 1 expected 0"); end
      checks++;
      if (mv) begin errors++; $display("FAIL basic_diff_stable: diff changed during SHIFT, expected hold"); end
   endtask

   task automatic test_vectors();
      logic [7:0] va [5] = '{8'd5,   8'h00, 8'hA5, 8'hFF, 8'h80};
      logic [7:0] vb [5] = '{8'd10,  8'hFF, 8'hA5, 8'h01, 8'h81};
      logic [7:0] vd [5] = '{8'hFB,  8'h01, 8'h00, 8'hFE, 8'hFF};
      logic       vo [5] = '{1'b1,   1'b1,  1'b0,  1'b0,  1'b1};
      logic [7:0] d; logic bo; int nb, nd; bit ov, mv, to;
      for (int k = 0; k < 5; k++) begin
         run_op(0, va[k], vb[k], d, bo, nb, nd, ov, mv, to);
         checks++;
         if (to || d !== vd[k] || bo !== vo[k]) begin
            errors++;
            $display("FAIL vec_%0d: %h-%h got diff=%h borrow=%b timeout=%b expected diff=%h borrow=%b",
                     k, va[k], vb[k], d, bo, to, vd[k], vo[k]);
         end
         checks++;
         if (nb !== 8 || nd !== 1 || ov || mv) begin
            errors++;
            $display("FAIL vec_%0d_timing: got busy=%0d done=%0d overlap=%b moved=%b expected 8/1/0/0",
                     k, nb, nd, ov, mv);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ndone, last_i, gap_err;
      ndone = 0; last_i = -1; gap_err = 0;
      bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd4;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (bus8.done) begin
            ndone++;
            checks++;
            if (bus8.diff !== 8'd5 || bus8.borrow_out !== 1'b0) begin
               errors++;
               $display("FAIL b2b_result_%0d: got diff=%0d borrow=%b expected 5/0", ndone, bus8.diff, bus8.borrow_out);
            end
            if (last_i >= 0 && (i - last_i) != 10) gap_err++;
            last_i = i;
         end
         // Valid operands only while IDLE; garbage while the op is running.
         if (!bus8.busy && !bus8.done) begin
            bus8.a = 8'd9; bus8.b = 8'd4;
         end else begin
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
         end
      end
      bus8.start = 1'b0;
      checks++;
      if (ndone !== 5) begin errors++; $display("FAIL b2b_count: got %0d done pulses expected 5", ndone); end
      checks++;
      if (gap_err !== 0) begin errors++; $display("FAIL b2b_period: got %0d bad gaps expected 0 (period 10)", gap_err); end
      for (int i = 0; i < 20; i++) begin
         if (!bus8.busy && !bus8.done) break;
         @(posedge clk); #1;
      end
      checks++;
      if (bus8.busy || bus8.done) begin errors++; $display("FAIL b2b_drain: got busy=%b done=%b expected idle", bus8.busy, bus8.done); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] d; logic bo; int nb, nd; bit ov, mv, to;
      bit saw_done;
      // Leave non-zero outputs behind so the reset clear is observable.
      run_op(0, 8'd5, 8'd10, d, bo, nb, nd, ov, mv, to);
      checks++;
      if (to || d !== 8'hFB || bo !== 1'b1) begin
         errors++; $display("FAIL abort_setup: got diff=%h borrow=%b expected FB/1", d, bo);
      end
      bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (bus8.busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", bus8.busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus8.diff !== 8'h00 || bus8.borrow_out !== 1'b0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear: got diff=%h borrow=%b busy=%b done=%b expected 00/0/0/0",
                  bus8.diff, bus8.borrow_out, bus8.busy, bus8.done);
      end
      saw_done = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus8.done || bus8.busy) saw_done = 1;
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) saw_done = 1;
      checks++;
      if (saw_done) begin errors++; $display("FAIL abort_no_done: got activity after abort expected none"); end
      run_op(0, 8'd100, 8'd1, d, bo, nb, nd, ov, mv, to);
      checks++;
      if (to || d !== 8'd99 || bo !== 1'b0 || nb !== 8) begin
         errors++; $display("FAIL abort_recover: got diff=%0d borrow=%b busy=%0d expected 99/0/8", d, bo, nb);
      end
   endtask

   task automatic test_sweep_w4();
      logic [7:0] d; logic bo; int nb, nd; bit ov, mv, to;
      logic [4:0] ref_full;
      int bad_timing;
      bad_timing = 0;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            run_op(1, 8'(ia), 8'(ib), d, bo, nb, nd, ov, mv, to);
            ref_full = 5'(ia) - 5'(ib);
            checks++;
            if (to || d !== {4'h0, ref_full[3:0]} || bo !== (ia < ib)) begin
               errors++;
               $display("FAIL sweep4 %0d-%0d: got diff=%h borrow=%b timeout=%b expected diff=%h borrow=%b",
                        ia, ib, d, bo, to, ref_full[3:0], (ia < ib));
            end
            if (nb != 4 || nd != 1 || ov || mv) bad_timing++;
         end
      end
      checks++;
      if (bad_timing !== 0) begin errors++; $display("FAIL sweep4_timing: got %0d bad ops expected 0", bad_timing); end
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0;
      test_reset();
      test_basic();
      test_vectors();
      test_back_to_back();
      test_reset_abort();
      test_sweep_w4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
